// File: rtl/tilt_pkg.sv
// Constants and arithmetic helpers shared by the tilt sensor datapath blocks
// (sample filter, angle display, alarm).
package tilt_pkg;

   localparam int ANGLE_W      = 11;   // signed tenths of a degree, covers +/-900
   localparam int ANGLE_MAX    = 900;  // output at +1 g
   localparam int ALARM_TENTHS = 800;  // 80-degree alarm threshold

   // Saturate v to the symmetric range [-lim, +lim].
   function automatic int clamp_sym(input int v, input int lim);
      if (v > lim) begin
         return lim;
      end else if (v < -lim) begin
         return -lim;
      end else begin
         return v;
      end
   endfunction

   // Divide by 2**sh, truncating toward zero. A bare arithmetic shift rounds
   // toward minus infinity, so negative values get a bias of 2**sh-1 first.
   function automatic int div_pow2_tz(input int v, input int sh);
      int bias;
      bias = (v < 0) ? ((1 << sh) - 1) : 0;
      return (v + bias) >>> sh;
   endfunction

endpackage

// File: rtl/sample_ring_avg.sv
// Moving-window accumulator: a ring of the last 2**AVG_LOG2 clamped samples
// with a running sum, write pointer and saturating fill counter.
module sample_ring_avg #(
   parameter int SAMPLE_W = 10,
   parameter int AVG_LOG2 = 3
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic                                sample_valid_i,
   input  logic signed [SAMPLE_W-1:0]          sample_i,
   output logic                                sum_valid_o,
   output logic signed [SAMPLE_W+AVG_LOG2-1:0] sum_o,
   output logic                                full_o
);

   localparam int DEPTH = 1 << AVG_LOG2;
   localparam int SUM_W = SAMPLE_W + AVG_LOG2;
   localparam int CNT_W = AVG_LOG2 + 1;
   localparam logic [CNT_W-1:0]    FULL_CNT = CNT_W'(DEPTH);
   localparam logic [AVG_LOG2-1:0] PTR_ONE  = AVG_LOG2'(1);
   localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);

   logic signed [SAMPLE_W-1:0] buf_q [DEPTH];
   logic        [AVG_LOG2-1:0] wr_ptr_q;
   logic        [CNT_W-1:0]    fill_q;
   logic signed [SUM_W-1:0]    sum_q;
   logic signed [SUM_W-1:0]    sum_d;
   logic                       valid_q;

   // Next running sum: add the incoming sample, drop the one it overwrites.
   always_comb begin
      // NOTE: sum_d is assigned unconditionally, so no latch can be inferred.
      sum_d = sum_q + SUM_W'(sample_i) - SUM_W'(buf_q[wr_ptr_q]);
   end

   // Window state update on each accepted sample.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: the ring is cleared on reset so that, before the window fills,
      // empty slots contribute zero to the sum instead of stale data.
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            buf_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         fill_q   <= '0;
         sum_q    <= '0;
         valid_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge value of the others (buf_q read in sum_d, then written).
         valid_q <= sample_valid_i;
         if (sample_valid_i) begin
            buf_q[wr_ptr_q] <= sample_i;
            wr_ptr_q        <= wr_ptr_q + PTR_ONE;  // wraps at 2**AVG_LOG2
            sum_q           <= sum_d;
            if (fill_q != FULL_CNT) begin
               fill_q <= fill_q + CNT_ONE;
            end
         end
      end
   end

   assign sum_valid_o = valid_q;
   assign sum_o       = sum_q;
   assign full_o      = (fill_q == FULL_CNT);

endmodule

// File: rtl/tilt_sample_filter.sv
// Conditioning stage between the SPI accelerometer controller and the angle
// display/alarm logic: edge-accept, clamp to +/-1 g, moving average, scale to
// signed tenths of a degree. Three-stage pipeline, no stall.
module tilt_sample_filter #(
   parameter int DATA_W    = 16,
   parameter int AVG_LOG2  = 3,
   parameter int FS_LOG2   = 8,
   parameter int ANGLE_MAX = tilt_pkg::ANGLE_MAX
) (
   input  logic                                 clk,
   input  logic                                 reset_n,
   input  logic                                 data_update,
   input  logic signed [DATA_W-1:0]             data_x,
   input  logic                                 freeze,
   output logic signed [tilt_pkg::ANGLE_W-1:0]  angle_tenths,
   output logic                                 angle_valid,
   output logic                                 primed
);

   localparam int SAMPLE_W = FS_LOG2 + 2;
   localparam int SUM_W    = SAMPLE_W + AVG_LOG2;
   localparam int PROD_W   = 21;
   localparam int ANGLE_W  = tilt_pkg::ANGLE_W;
   localparam int FS_LIMIT = 1 << FS_LOG2;

   logic                       upd_prev_q;
   logic                       accept;
   logic signed [SAMPLE_W-1:0] clamp_d;
   logic signed [SAMPLE_W-1:0] clamp_q;
   logic                       s1_valid_q;
   logic                       s2_valid;
   logic signed [SUM_W-1:0]    s2_sum;
   logic                       s2_full;
   int                         avg;
   logic signed [PROD_W-1:0]   prod;
   logic signed [ANGLE_W-1:0]  angle_d;
   logic signed [ANGLE_W-1:0]  angle_q;
   logic                       valid_q;
   logic                       primed_q;

   // A held level yields one sample: accept only on the low-to-high edge.
   assign accept = data_update & ~upd_prev_q;

   // Previous data_update level for edge detection.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         upd_prev_q <= 1'b0;
      end else begin
         upd_prev_q <= data_update;
      end
   end

   // Clamp the raw sample to +/-1 g.
   always_comb begin
      clamp_d = SAMPLE_W'(tilt_pkg::clamp_sym(int'(data_x), FS_LIMIT));
   end

   // S1: register the clamped sample on an accepted edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid_q <= 1'b0;
         clamp_q    <= '0;
      end else begin
         s1_valid_q <= accept;
         if (accept) begin
            clamp_q <= clamp_d;
         end
      end
   end

   // S2: ring buffer and running sum.
   sample_ring_avg #(
      .SAMPLE_W (SAMPLE_W),
      .AVG_LOG2 (AVG_LOG2)
   ) u_ring (
      .clk            (clk),
      .reset_n        (reset_n),
      .sample_valid_i (s1_valid_q),
      .sample_i       (clamp_q),
      .sum_valid_o    (s2_valid),
      .sum_o          (s2_sum),
      .full_o         (s2_full)
   );

   // Average, then scale to tenths of a degree; both divides truncate toward zero.
   always_comb begin
      avg     = tilt_pkg::div_pow2_tz(int'(s2_sum), AVG_LOG2);
      prod    = PROD_W'(avg * ANGLE_MAX);
      angle_d = ANGLE_W'(tilt_pkg::div_pow2_tz(int'(prod), FS_LOG2));
   end

   // S3: publish the angle unless frozen; primed latches once the window is full.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         angle_q  <= '0;
         valid_q  <= 1'b0;
         primed_q <= 1'b0;
      end else begin
         valid_q <= s2_valid & ~freeze;
         if (s2_valid && !freeze) begin
            angle_q <= angle_d;
         end
         if (s2_valid && s2_full) begin
            primed_q <= 1'b1;
         end
      end
   end

   assign angle_tenths = angle_q;
   assign angle_valid  = valid_q;
   assign primed       = primed_q;

endmodule

// File: tb/tb_tilt_sample_filter.sv
// Self-checking bench for tilt_sample_filter: directed table, multi-cycle
// corner sequences and randomized stimulus against a window-average model.
module tb_tilt_sample_filter;

   localparam int N_VEC = 16;

   typedef struct {
      bit do_reset;
      int data;
      int exp_angle;
      bit exp_primed;
   } vec_t;

   typedef struct {
      int angle;
      bit primed;
      int cyc;
   } obs_t;

   typedef struct {
      int c0;
      int angle;
      bit primed;
   } pend_t;

   logic                clk = 1'b0;
   logic                reset_n;
   logic                data_update;
   logic signed [15:0]  data_x;
   logic                freeze;
   logic signed [10:0]  angle_tenths;
   logic                angle_valid;
   logic                primed;

   int      n_checks = 0;
   int      n_errors = 0;
   int      cyc = 0;
   obs_t    obs_q[$];
   pend_t   pend_q[$];
   bit      freeze_log[int];
   int      win[8];
   int      widx;
   int      wcnt;
   vec_t    vecs[N_VEC];
   int      exp_pos[8];

   tilt_sample_filter dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .data_update  (data_update),
      .data_x       (data_x),
      .freeze       (freeze),
      .angle_tenths (angle_tenths),
      .angle_valid  (angle_valid),
      .primed       (primed)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record freeze level and every output pulse, away from the active edge.
   always @(negedge clk) begin
      freeze_log[cyc] = freeze;
      if (angle_valid) obs_q.push_back('{int'(angle_tenths), primed, cyc});
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1);
   end

   task automatic check(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      foreach (win[i]) win[i] = 0;
      widx = 0;
      wcnt = 0;
   endtask

   // Window of the last 8 clamped samples; average and scale with integer
   // division, which truncates toward zero.
   task automatic model_accept(input int d, output int ang, output bit pr);
      int c;
      int s;
      c = (d > 256) ? 256 : ((d < -256) ? -256 : d);
      win[widx] = c;
      widx = (widx + 1) % 8;
      if (wcnt < 8) wcnt++;
      s = 0;
      foreach (win[i]) s += win[i];
      ang = ((s / 8) * 900) / 256;
      pr  = (wcnt == 8);
   endtask

   // Raise data_update for 'hold' cycles, then hold it low for 'gap' cycles.
   task automatic send(input int d, input int hold, input int gap);
      int c0;
      int ang;
      bit pr;
      c0 = cyc;
      data_x = 16'(d);
      data_update = 1'b1;
      repeat (hold) tick();
      data_update = 1'b0;
      repeat (gap) tick();
      model_accept(d, ang, pr);
      pend_q.push_back('{c0, ang, pr});
   endtask

   // Match observed pulses to model expectations; a sample is expected to
   // appear 3 cycles after its edge unless freeze was high in its S3 cycle.
   task automatic compare_all(input string nm);
      obs_t o;
      bit   fz;
      repeat (5) tick();
      foreach (pend_q[i]) begin
         fz = freeze_log.exists(pend_q[i].c0 + 2) ? freeze_log[pend_q[i].c0 + 2] : 1'b0;
         if (!fz) begin
            if (obs_q.size() == 0) begin
               check($sformatf("%s[%0d] valid count", nm, i), 0, 1);
            end else begin
               o = obs_q.pop_front();
               check($sformatf("%s[%0d] latency", nm, i), o.cyc - pend_q[i].c0, 3);
               check($sformatf("%s[%0d] angle", nm, i), o.angle, pend_q[i].angle);
               check($sformatf("%s[%0d] primed", nm, i), int'(o.primed), int'(pend_q[i].primed));
            end
         end
      end
      check($sformatf("%s extra valids", nm), obs_q.size(), 0);
      obs_q.delete();
      pend_q.delete();
   endtask

   task automatic do_reset();
      reset_n     = 1'b0;
      data_update = 1'b0;
      freeze      = 1'b0;
      data_x      = '0;
      repeat (2) tick();
      reset_n = 1'b1;
      tick();
      model_reset();
      obs_q.delete();
      pend_q.delete();
   endtask

   initial begin
      int d;
      reset_n     = 1'b0;
      data_update = 1'b0;
      freeze      = 1'b0;
      data_x      = '0;
      model_reset();

      exp_pos = '{112, 225, 337, 450, 562, 675, 787, 900};
      for (int i = 0; i < 8; i++) begin
         vecs[i]     = '{(i == 0), 256, exp_pos[i], (i == 7)};
         vecs[i + 8] = '{(i == 0), -300, -exp_pos[i], (i == 7)};
      end

      repeat (2) tick();
      reset_n = 1'b1;
      tick();
      check("reset angle_tenths", int'(angle_tenths), 0);
      check("reset angle_valid", int'(angle_valid), 0);
      check("reset primed", int'(primed), 0);

      // Directed table: full-scale ramp up, then clamped negative ramp.
      for (int i = 0; i < N_VEC; i++) begin
         if (vecs[i].do_reset) do_reset();
         send(vecs[i].data, 1, 1);
         repeat (3) tick();
         check($sformatf("vec%0d pulses", i), obs_q.size(), 1);
         if (obs_q.size() > 0) begin
            check($sformatf("vec%0d angle", i), obs_q[0].angle, vecs[i].exp_angle);
            check($sformatf("vec%0d primed", i), int'(obs_q[0].primed), int'(vecs[i].exp_primed));
         end
         compare_all($sformatf("vec%0d", i));
      end

      // Level held high 10 cycles: one sample only.
      do_reset();
      send(128, 10, 1);
      repeat (3) tick();
      check("held pulses", obs_q.size(), 1);
      if (obs_q.size() > 0) check("held angle", obs_q[0].angle, 56);
      compare_all("held");

      // Freeze holds the output while the window keeps filling.
      do_reset();
      repeat (8) send(128, 1, 1);
      compare_all("prime128");
      check("prime128 angle", int'(angle_tenths), 450);
      check("prime128 primed", int'(primed), 1);
      freeze = 1'b1;
      repeat (8) send(-256, 1, 1);
      compare_all("frozen");
      check("frozen hold angle", int'(angle_tenths), 450);
      freeze = 1'b0;
      send(-256, 1, 1);
      repeat (3) tick();
      check("unfreeze pulses", obs_q.size(), 1);
      if (obs_q.size() > 0) check("unfreeze angle", obs_q[0].angle, -900);
      compare_all("unfreeze");

      // Maximum accept rate, alternating full scale.
      do_reset();
      for (int i = 0; i < 16; i++) send((i % 2 == 0) ? 256 : -256, 1, 1);
      compare_all("maxrate");

      // Reset between edge+1 and edge+2 discards the in-flight sample.
      do_reset();
      repeat (8) send(256, 1, 1);
      compare_all("preset");
      check("preset primed", int'(primed), 1);
      data_x = 16'sd256;
      data_update = 1'b1;
      tick();
      #1 reset_n = 1'b0;
      data_update = 1'b0;
      #1 reset_n = 1'b1;
      model_reset();
      repeat (6) tick();
      check("midreset pulses", obs_q.size(), 0);
      check("midreset angle", int'(angle_tenths), 0);
      check("midreset primed", int'(primed), 0);
      check("midreset valid", int'(angle_valid), 0);
      obs_q.delete();
      send(256, 1, 1);
      compare_all("postreset");

      // Randomized samples, spacing and freeze against the model.
      do_reset();
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) freeze = ~freeze;
         d = int'($urandom_range(0, 1400)) - 700;
         send(d, int'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
      end
      freeze = 1'b0;
      compare_all("random");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
